// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline register with a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid_o when the stage is empty; 1 entry/cycle steady state.
// Backpressure: in_ready_o = ~skid_v (flop only), so out_ready_i never reaches in_ready_o combinationally.
//
// Ports: clk_i/rst_i (sync, active-high); flush_i drops held entries; in_valid_i/in_ready_o with
// reg_waddr_i/reg_we_i/reg_wdata_i/sb_i from EXE; out_valid_o/out_ready_i with reg_*_o/sb_o toward
// MEM; stall_cnt_o counts cycles with a held entry refused by MEM, cleared by stat_clr_i.
module exe_mem_skid #(
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32,
    parameter int SB_WIDTH    = 8,
    parameter int X0_SUPPRESS = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [SB_WIDTH-1:0]    sb_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic [SB_WIDTH-1:0]    sb_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    input  logic                   stat_clr_i
);

    // Encoding keeps main_v in bit 0 and skid_v in bit 1.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic main_v, skid_v;
    logic accept, drain;
    logic in_we;
    logic load_main_in, load_main_skid, load_skid_in;

    logic [RADDR_WIDTH-1:0] main_waddr, skid_waddr;
    logic                   main_we,    skid_we;
    logic [RDATA_WIDTH-1:0] main_wdata, skid_wdata;
    logic [SB_WIDTH-1:0]    main_sb,    skid_sb;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign main_v     = (state_q != ST_EMPTY);
    assign skid_v     = (state_q == ST_FULL);
    assign in_ready_o = ~skid_v;
    assign accept     = in_valid_i & in_ready_o;
    assign drain      = main_v & out_ready_i;

    // Writes to x0 are architecturally dead; dropping the enable here keeps MEM/WB from seeing them.
    assign in_we = reg_we_i & ~((X0_SUPPRESS != 0) & (reg_waddr_i == '0));

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush_i) begin
            // Flush wins over accept/drain; payload regs are left stale, valid gating hides them.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid_in = 1'b1;
                        state_d      = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            main_waddr <= '0;
            main_we    <= 1'b0;
            main_wdata <= '0;
            main_sb    <= '0;
            skid_waddr <= '0;
            skid_we    <= 1'b0;
            skid_wdata <= '0;
            skid_sb    <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_waddr <= reg_waddr_i;
                main_we    <= in_we;
                main_wdata <= reg_wdata_i;
                main_sb    <= sb_i;
            end else if (load_main_skid) begin
                main_waddr <= skid_waddr;
                main_we    <= skid_we;
                main_wdata <= skid_wdata;
                main_sb    <= skid_sb;
            end
            if (load_skid_in) begin
                skid_waddr <= reg_waddr_i;
                skid_we    <= in_we;
                skid_wdata <= reg_wdata_i;
                skid_sb    <= sb_i;
            end
        end
    end

    // Saturating stall counter; clear beats increment, flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid_o = main_v;
    assign reg_we_o    = main_v & main_we;
    assign reg_waddr_o = main_waddr;
    assign reg_wdata_o = main_wdata;
    assign sb_o        = main_sb;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_exe_mem_skid.sv
// Directed bench for exe_mem_skid: vector table plus streaming and counter-saturation sequences.
// Two instances share inputs: u0 (defaults) and u1 (x0 writes kept, 3-bit stall counter).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time unit after the edge.
module tb_exe_mem_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, reg_we, out_ready, stat_clr;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [7:0]  sb;

    logic        ov0, ir0, we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [7:0]  sb0;
    logic [15:0] cnt0;

    logic        ov1, ir1, we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [7:0]  sb1;
    logic [2:0]  cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exe_mem_skid u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir0),
        .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .sb_i(sb),
        .out_valid_o(ov0), .out_ready_i(out_ready),
        .reg_waddr_o(wa0), .reg_we_o(we0), .reg_wdata_o(wd0), .sb_o(sb0),
        .stall_cnt_o(cnt0), .stat_clr_i(stat_clr)
    );

    exe_mem_skid #(.X0_SUPPRESS(0), .STALL_CNT_W(3)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir1),
        .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .sb_i(sb),
        .out_valid_o(ov1), .out_ready_i(out_ready),
        .reg_waddr_o(wa1), .reg_we_o(we1), .reg_wdata_o(wd1), .sb_o(sb1),
        .stall_cnt_o(cnt1), .stat_clr_i(stat_clr)
    );

    typedef struct {
        string       name;
        logic        rst, flush, iv;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic [7:0]  sb;
        logic        ordy, clr;
        logic        e_ov, e_ir;
        logic [4:0]  e_wa;
        logic        e_we, e_we1;
        logic [31:0] e_wd;
        logic [7:0]  e_sb;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [4:0] wa,
                         input logic we, input logic [31:0] wd, input logic [7:0] s,
                         input logic ordy, input logic clr);
        rst = r; flush = f; in_valid = iv; reg_waddr = wa; reg_we = we;
        reg_wdata = wd; sb = s; out_ready = ordy; stat_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic e_ov, input logic e_ir,
                           input logic [4:0] e_wa, input logic e_we, input logic e_we1,
                           input logic [31:0] e_wd, input logic [7:0] e_sb,
                           input logic [15:0] e_cnt, input logic [2:0] e_cnt1);
        chk({name, ".ov"},   {31'd0, ov0}, {31'd0, e_ov});
        chk({name, ".ir"},   {31'd0, ir0}, {31'd0, e_ir});
        chk({name, ".wa"},   {27'd0, wa0}, {27'd0, e_wa});
        chk({name, ".we"},   {31'd0, we0}, {31'd0, e_we});
        chk({name, ".wd"},   wd0,          e_wd);
        chk({name, ".sb"},   {24'd0, sb0}, {24'd0, e_sb});
        chk({name, ".cnt"},  {16'd0, cnt0}, {16'd0, e_cnt});
        chk({name, ".ov1"},  {31'd0, ov1}, {31'd0, e_ov});
        chk({name, ".ir1"},  {31'd0, ir1}, {31'd0, e_ir});
        chk({name, ".wa1"},  {27'd0, wa1}, {27'd0, e_wa});
        chk({name, ".we1"},  {31'd0, we1}, {31'd0, e_we1});
        chk({name, ".wd1"},  wd1,          e_wd);
        chk({name, ".sb1"},  {24'd0, sb1}, {24'd0, e_sb});
        chk({name, ".cnt1"}, {29'd0, cnt1}, {29'd0, e_cnt1});
    endtask

    initial begin
        //         name       rst fl iv wa  we wdata         sb     ordy clr | ov ir wa  we we1 wd            sb     cnt
        vt[0]  = '{"rst0",    1, 0, 1, 3,  1, 32'h55,       8'h11, 0, 0,  0, 1, 0,  0, 0, 32'h0,        8'h00, 0};
        vt[1]  = '{"rst1",    1, 0, 1, 3,  1, 32'h55,       8'h11, 0, 0,  0, 1, 0,  0, 0, 32'h0,        8'h00, 0};
        vt[2]  = '{"release", 0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 0,  0, 1, 0,  0, 0, 32'h0,        8'h00, 0};
        vt[3]  = '{"bp_A",    0, 0, 1, 5,  1, 32'hA,        8'hA1, 0, 0,  1, 1, 5,  1, 1, 32'hA,        8'hA1, 0};
        vt[4]  = '{"bp_B",    0, 0, 1, 6,  1, 32'hB,        8'hB1, 0, 0,  1, 0, 5,  1, 1, 32'hA,        8'hA1, 1};
        vt[5]  = '{"bp_hold", 0, 0, 1, 7,  1, 32'hC,        8'hC1, 0, 0,  1, 0, 5,  1, 1, 32'hA,        8'hA1, 2};
        vt[6]  = '{"bp_outB", 0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 0,  1, 1, 6,  1, 1, 32'hB,        8'hB1, 2};
        vt[7]  = '{"bp_empt", 0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 0,  0, 1, 6,  0, 0, 32'hB,        8'hB1, 2};
        vt[8]  = '{"fl_D",    0, 0, 1, 8,  1, 32'hD,        8'hD1, 0, 0,  1, 1, 8,  1, 1, 32'hD,        8'hD1, 2};
        vt[9]  = '{"fl_E",    0, 0, 1, 9,  1, 32'hE,        8'hE1, 0, 0,  1, 0, 8,  1, 1, 32'hD,        8'hD1, 3};
        vt[10] = '{"flush",   0, 1, 1, 7,  1, 32'hC,        8'hC1, 1, 0,  0, 1, 8,  0, 0, 32'hD,        8'hD1, 3};
        vt[11] = '{"fl_idle", 0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 0,  0, 1, 8,  0, 0, 32'hD,        8'hD1, 3};
        vt[12] = '{"x0",      0, 0, 1, 0,  1, 32'hDEADBEEF, 8'h5A, 1, 0,  1, 1, 0,  0, 1, 32'hDEADBEEF, 8'h5A, 3};
        vt[13] = '{"x0_out",  0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 0,  0, 1, 0,  0, 0, 32'hDEADBEEF, 8'h5A, 3};
        vt[14] = '{"clr",     0, 0, 0, 0,  0, 32'h0,        8'h00, 1, 1,  0, 1, 0,  0, 0, 32'hDEADBEEF, 8'h5A, 0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; reg_waddr = '0; reg_we = 1'b0;
        reg_wdata = '0; sb = '0; out_ready = 1'b0; stat_clr = 1'b0;
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].waddr, vt[i].we, vt[i].wdata,
                  vt[i].sb, vt[i].ordy, vt[i].clr);
            chk_all(vt[i].name, vt[i].e_ov, vt[i].e_ir, vt[i].e_wa, vt[i].e_we, vt[i].e_we1,
                    vt[i].e_wd, vt[i].e_sb, vt[i].e_cnt,
                    (vt[i].e_cnt > 16'd7) ? 3'd7 : vt[i].e_cnt[2:0]);
        end

        // Streaming: each entry visible one edge after it is offered, no bubbles.
        for (int n = 1; n <= 8; n++) begin
            drive(0, 0, 1, 5'(n), 1, 32'h100 + 32'(n), 8'(n), 1, 0);
            chk_all($sformatf("stream%0d", n), 1, 1, 5'(n), 1, 1, 32'h100 + 32'(n), 8'(n), 0, 0);
        end
        drive(0, 0, 0, 0, 0, 32'h0, 8'h00, 1, 0);
        chk_all("stream_end", 0, 1, 5'd8, 0, 0, 32'h108, 8'd8, 0, 0);

        // Counter saturation: load one entry, then stall 10 cycles.
        drive(0, 0, 1, 5'd4, 1, 32'h44, 8'h44, 0, 0);
        chk_all("sat_load", 1, 1, 5'd4, 1, 1, 32'h44, 8'h44, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 8'h00, 0, 0);
            chk_all($sformatf("sat%0d", k), 1, 1, 5'd4, 1, 1, 32'h44, 8'h44,
                    16'(k), (k > 7) ? 3'd7 : 3'(k));
        end
        // Clear in the same cycle as a stall: clear wins.
        drive(0, 0, 0, 0, 0, 32'h0, 8'h00, 0, 1);
        chk_all("sat_clr", 1, 1, 5'd4, 1, 1, 32'h44, 8'h44, 0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 8'h00, 1, 0);
        chk_all("sat_drain", 0, 1, 5'd4, 0, 0, 32'h44, 8'h44, 0, 0);

        // Reset mid-stall discards held entries and clears everything.
        drive(0, 0, 1, 5'd2, 1, 32'h22, 8'h22, 0, 0);
        drive(0, 0, 1, 5'd3, 1, 32'h33, 8'h33, 0, 0);
        chk_all("pre_rst", 1, 0, 5'd2, 1, 1, 32'h22, 8'h22, 1, 1);
        drive(1, 1, 1, 5'd9, 1, 32'h99, 8'h99, 0, 0);
        chk_all("mid_rst", 0, 1, 5'd0, 0, 0, 32'h0, 8'h00, 0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 8'h00, 1, 0);
        chk_all("post_rst", 0, 1, 5'd0, 0, 0, 32'h0, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
